// File: rtl/rv_cpu.sv
// rv_cpu: single-cycle RV32I-subset core with a fixed 32-word program ROM,
// a 32x32 register file and a 32-word data RAM. The low ten bits of x10
// are the only architectural output.
module rv_cpu (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] out
);

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  // {funct7, funct3} selectors for the register-register ALU group
  localparam logic [9:0] FN_ADD = {7'b0000000, 3'b000};
  localparam logic [9:0] FN_SUB = {7'b0100000, 3'b000};
  localparam logic [9:0] FN_SLT = {7'b0000000, 3'b010};
  localparam logic [9:0] FN_XOR = {7'b0000000, 3'b100};
  localparam logic [9:0] FN_OR  = {7'b0000000, 3'b110};
  localparam logic [9:0] FN_AND = {7'b0000000, 3'b111};

  logic [31:0] pc_r;
  logic [31:0] regs_r [0:31];
  logic [31:0] dmem_r [0:31];

  logic [31:0] instr_s;
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_st_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_j_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic [31:0] pc_plus4_s;
  logic [4:0]  load_idx_s;
  logic [4:0]  store_idx_s;
  logic [31:0] load_data_s;
  logic        wb_en_s;
  logic [31:0] wb_data_s;
  logic        mem_we_s;
  logic [31:0] next_pc_s;

  // Program ROM; every word past the halt loop is a NOP.
  function automatic logic [31:0] rom_word(input logic [4:0] idx);
    case (idx)
      5'd0:    rom_word = 32'h0050_0093; // addi x1,x0,5
      5'd1:    rom_word = 32'h0030_0113; // addi x2,x0,3
      5'd2:    rom_word = 32'h0020_8533; // add  x10,x1,x2
      5'd3:    rom_word = 32'h4020_8533; // sub  x10,x1,x2
      5'd4:    rom_word = 32'h0020_F533; // and  x10,x1,x2
      5'd5:    rom_word = 32'h0020_E533; // or   x10,x1,x2
      5'd6:    rom_word = 32'h0020_C533; // xor  x10,x1,x2
      5'd7:    rom_word = 32'h0011_2533; // slt  x10,x2,x1
      5'd8:    rom_word = 32'h0010_2023; // sw   x1,0(x0)
      5'd9:    rom_word = 32'h0000_2503; // lw   x10,0(x0)
      5'd10:   rom_word = 32'h0040_0193; // addi x3,x0,4
      5'd11:   rom_word = 32'h0645_0513; // addi x10,x10,100
      5'd12:   rom_word = 32'hFFF1_8193; // addi x3,x3,-1
      5'd13:   rom_word = 32'hFE01_9CE3; // bne  x3,x0,-8
      5'd14:   rom_word = 32'h0000_006F; // jal  x0,0 (halt)
      default: rom_word = NOP_WORD;
    endcase
  endfunction

  // RAM word index of base+offset; the two byte-offset bits are dropped.
  function automatic logic [4:0] word_idx(input logic [31:0] base, input logic [31:0] offs);
    logic [31:0] sum;
    sum = base + offs;
    return sum[6:2];
  endfunction

  assign instr_s  = rom_word(pc_r[6:2]);
  assign opcode_s = instr_s[6:0];
  assign rd_s     = instr_s[11:7];
  assign funct3_s = instr_s[14:12];
  assign rs1_s    = instr_s[19:15];
  assign rs2_s    = instr_s[24:20];
  assign funct7_s = instr_s[31:25];

  assign imm_i_s  = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_st_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s  = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_j_s  = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

  // x0 is forced to zero on read so it never depends on stored contents.
  assign rs1_val_s   = (rs1_s == 5'd0) ? 32'd0 : regs_r[rs1_s];
  assign rs2_val_s   = (rs2_s == 5'd0) ? 32'd0 : regs_r[rs2_s];
  assign pc_plus4_s  = pc_r + 32'd4;
  assign load_idx_s  = word_idx(rs1_val_s, imm_i_s);
  assign store_idx_s = word_idx(rs1_val_s, imm_st_s);
  assign load_data_s = dmem_r[load_idx_s];

  // Decode/execute: choose writeback, store enable and next PC; unknown encodings act as NOP.
  always_comb begin
    wb_en_s   = 1'b0;
    wb_data_s = 32'd0;
    mem_we_s  = 1'b0;
    next_pc_s = pc_plus4_s;
    case (opcode_s)
      OP_R: begin
        wb_en_s = 1'b1;
        case ({funct7_s, funct3_s})
          FN_ADD:  wb_data_s = rs1_val_s + rs2_val_s;
          FN_SUB:  wb_data_s = rs1_val_s - rs2_val_s;
          FN_SLT:  wb_data_s = {31'd0, ($signed(rs1_val_s) < $signed(rs2_val_s))};
          FN_XOR:  wb_data_s = rs1_val_s ^ rs2_val_s;
          FN_OR:   wb_data_s = rs1_val_s | rs2_val_s;
          FN_AND:  wb_data_s = rs1_val_s & rs2_val_s;
          default: wb_en_s   = 1'b0;
        endcase
      end
      OP_IMM: begin
        if (funct3_s == 3'b000) begin
          wb_en_s   = 1'b1;
          wb_data_s = rs1_val_s + imm_i_s;
        end else begin
          wb_en_s   = 1'b0;
        end
      end
      OP_LOAD: begin
        if (funct3_s == 3'b010) begin
          wb_en_s   = 1'b1;
          wb_data_s = load_data_s;
        end else begin
          wb_en_s   = 1'b0;
        end
      end
      OP_STORE: begin
        if (funct3_s == 3'b010) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      OP_BRANCH: begin
        case (funct3_s)
          3'b000: begin
            if (rs1_val_s == rs2_val_s) begin
              next_pc_s = pc_r + imm_b_s;
            end else begin
              next_pc_s = pc_plus4_s;
            end
          end
          3'b001: begin
            if (rs1_val_s != rs2_val_s) begin
              next_pc_s = pc_r + imm_b_s;
            end else begin
              next_pc_s = pc_plus4_s;
            end
          end
          default: next_pc_s = pc_plus4_s;
        endcase
      end
      OP_JAL: begin
        wb_en_s   = 1'b1;
        wb_data_s = pc_plus4_s;
        next_pc_s = pc_r + imm_j_s;
      end
      default: begin
        wb_en_s = 1'b0;
      end
    endcase
  end

  // Architectural state update; reset clears PC, registers and RAM and overrides the instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
        dmem_r[i] <= 32'd0;
      end
    end else begin
      pc_r <= next_pc_s;
      if (wb_en_s && (rd_s != 5'd0)) begin
        regs_r[rd_s] <= wb_data_s;
      end
      if (mem_we_s) begin
        dmem_r[store_idx_s] <= rs2_val_s;
      end
    end
  end

  assign out = regs_r[10][9:0];

endmodule

// File: tb/tb_rv_cpu.sv
// tb_rv_cpu: drives rv_cpu with directed and randomized reset patterns and
// compares out/PC/state against an instruction-level model of the program.
module tb_rv_cpu;

  logic       clk;
  logic       reset;
  logic [9:0] out;

  rv_cpu dut (
    .clk   (clk),
    .reset (reset),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_NOP, K_ADDI, K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLT,
                    K_LW, K_SW, K_BEQ, K_BNE, K_JAL} kind_t;
  typedef struct {
    kind_t k;
    int    rd;
    int    rs1;
    int    rs2;
    int    imm;
  } ins_t;

  ins_t        prog [0:31];
  logic [31:0] m_x   [0:31];
  logic [31:0] m_ram [0:31];
  logic [31:0] m_pc;
  int          exp_tab [0:24];
  int          total;
  int          bad;
  int          edge_n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
    end
  endtask

  task automatic set_ins(input int i, input kind_t k, input int rd, input int rs1, input int rs2, input int imm);
    prog[i].k   = k;
    prog[i].rd  = rd;
    prog[i].rs1 = rs1;
    prog[i].rs2 = rs2;
    prog[i].imm = imm;
  endtask

  // One architectural step of the program listing (or a reset).
  task automatic model_edge(input logic rst);
    ins_t        p;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] v;
    logic [31:0] npc;
    logic        wr;
    int          idx;
    int          mi;
    if (rst) begin
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) begin
        m_x[i]   = 32'd0;
        m_ram[i] = 32'd0;
      end
    end else begin
      idx = int'((m_pc >> 2) & 32'd31);
      p   = prog[idx];
      a   = m_x[p.rs1];
      b   = m_x[p.rs2];
      npc = m_pc + 32'd4;
      wr  = 1'b0;
      v   = 32'd0;
      mi  = int'(((a + p.imm) >> 2) & 32'd31);
      case (p.k)
        K_ADDI: begin v = a + p.imm; wr = 1'b1; end
        K_ADD:  begin v = a + b; wr = 1'b1; end
        K_SUB:  begin v = a - b; wr = 1'b1; end
        K_AND:  begin v = a & b; wr = 1'b1; end
        K_OR:   begin v = a | b; wr = 1'b1; end
        K_XOR:  begin v = a ^ b; wr = 1'b1; end
        K_SLT:  begin v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1'b1; end
        K_LW:   begin v = m_ram[mi]; wr = 1'b1; end
        K_SW:   m_ram[mi] = b;
        K_BEQ:  if (a == b) npc = m_pc + p.imm;
        K_BNE:  if (a != b) npc = m_pc + p.imm;
        K_JAL:  begin v = m_pc + 32'd4; wr = 1'b1; npc = m_pc + p.imm; end
        default: ;
      endcase
      if (wr && p.rd != 0) m_x[p.rd] = v;
      m_pc = npc;
    end
  endtask

  // Apply reset level for one clock edge, advance the model, compare after the edge.
  task automatic tick(input logic rst);
    @(negedge clk);
    reset = rst;
    @(posedge clk);
    model_edge(rst);
    #1;
    if (rst) edge_n = 0;
    else     edge_n++;
    check_val("out_vs_model", {22'd0, out}, {22'd0, m_x[10][9:0]});
    check_val("pc_vs_model", dut.pc_r, m_pc);
  endtask

  // Run n edges with reset low, checking the published out sequence and milestones.
  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0);
      if (edge_n <= 24 && exp_tab[edge_n] >= 0)
        check_val("seq_out", {22'd0, out}, exp_tab[edge_n]);
      if (edge_n == 10) check_val("ram0_after_lw", dut.dmem_r[0], 32'd5);
      if (edge_n == 22) check_val("x3_zero", dut.regs_r[3], 32'd0);
      if (edge_n == 24) check_val("halt_pc", dut.pc_r, 32'h38);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    edge_n = 0;
    reset  = 1'b1;

    for (int i = 0; i < 32; i++) set_ins(i, K_NOP, 0, 0, 0, 0);
    set_ins(0,  K_ADDI, 1, 0, 0, 5);
    set_ins(1,  K_ADDI, 2, 0, 0, 3);
    set_ins(2,  K_ADD, 10, 1, 2, 0);
    set_ins(3,  K_SUB, 10, 1, 2, 0);
    set_ins(4,  K_AND, 10, 1, 2, 0);
    set_ins(5,  K_OR,  10, 1, 2, 0);
    set_ins(6,  K_XOR, 10, 1, 2, 0);
    set_ins(7,  K_SLT, 10, 2, 1, 0);
    set_ins(8,  K_SW,   0, 0, 1, 0);
    set_ins(9,  K_LW,  10, 0, 0, 0);
    set_ins(10, K_ADDI, 3, 0, 0, 4);
    set_ins(11, K_ADDI,10,10, 0, 100);
    set_ins(12, K_ADDI, 3, 3, 0, -1);
    set_ins(13, K_BNE,  0, 3, 0, -8);
    set_ins(14, K_JAL,  0, 0, 0, 0);

    for (int i = 0; i <= 24; i++) exp_tab[i] = -1;
    exp_tab[1] = 0;   exp_tab[2] = 0;   exp_tab[3] = 8;   exp_tab[4] = 2;
    exp_tab[5] = 1;   exp_tab[6] = 7;   exp_tab[7] = 6;   exp_tab[8] = 1;
    exp_tab[9] = 1;   exp_tab[10] = 5;  exp_tab[11] = 5;  exp_tab[12] = 105;
    exp_tab[15] = 205; exp_tab[18] = 305;
    for (int i = 21; i <= 24; i++) exp_tab[i] = 405;

    // Power-on reset for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      check_val("rst_out", {22'd0, out}, 32'd0);
    end
    check_val("rst_pc", dut.pc_r, 32'd0);
    check_val("rst_ram0", dut.dmem_r[0], 32'd0);

    // Full program run into the halt loop
    run_edges(24);
    for (int i = 0; i < 100; i++) begin
      tick(1'b0);
      check_val("halt_pc_hold", dut.pc_r, 32'h38);
      check_val("halt_out_hold", {22'd0, out}, 32'd405);
    end
    check_val("halt_x1", dut.regs_r[1], 32'd5);
    check_val("halt_x2", dut.regs_r[2], 32'd3);
    check_val("halt_x0", dut.regs_r[0], 32'd0);
    check_val("halt_ram0", dut.dmem_r[0], 32'd5);

    // Mid-run reset at edge 16 for 3 cycles, then the sequence must repeat
    for (int i = 0; i < 10; i++) tick(1'b1);
    run_edges(15);
    tick(1'b1);
    check_val("midrst_out", {22'd0, out}, 32'd0);
    check_val("midrst_ram0", dut.dmem_r[0], 32'd0);
    check_val("midrst_pc", dut.pc_r, 32'd0);
    tick(1'b1);
    tick(1'b1);
    run_edges(24);

    // Randomized reset pulses and run lengths against the model
    for (int s = 0; s < 25; s++) begin
      int rl;
      int run;
      rl  = int'($urandom_range(1, 3));
      run = int'($urandom_range(1, 40));
      for (int i = 0; i < rl; i++) tick(1'b1);
      run_edges(run);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_cpu.md
# rv_cpu

Single-cycle RV32I-subset processor with a fixed on-chip program ROM, a 32x32 register file and a 32-word data memory. The only architectural output is the low 10 bits of register x10, which serves as the observable result bus of the CPU. It sits at the top of the demo design and is driven directly by the board/bench clock and reset.

## Interface
- No parameters. Sizes are fixed: 32-bit datapath, 32-entry ROM, 32-entry data RAM.
- `clk`  input  1  — single system clock; all state updates on the rising edge.
- `reset`  input  1  — synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `out`  output  10  — `x10[9:0]`, taken directly from the register-file flop, with no extra pipeline stage.

## Operation
- State:
  - PC: 32-bit.
  - Register file: x0..x31, 32-bit; x0 reads 0 and ignores writes.
  - Data RAM: 32 x 32-bit, word index `addr[6:2]`, low two address bits ignored.
- ROM: 32 x 32-bit, indexed by `PC[6:2]`, so it wraps every 128 bytes. Entries 15..31 hold NOP (`addi x0,x0,0`).
- Each cycle fetches, decodes, executes, and writes back one instruction.
- Supported instructions, standard RV32I encodings:
  - ADD, SUB, AND, OR, XOR, SLT (signed).
  - ADDI.
  - LW, SW.
  - BEQ, BNE.
  - JAL, which writes rd = PC+4.
- Any other opcode executes as a NOP: PC+4, no writes.
- Next PC: PC+4 by default. A taken branch or JAL loads PC + sign-extended immediate.
- Fixed ROM program, word index: instruction:
  - 0: `addi x1,x0,5`
  - 1: `addi x2,x0,3`
  - 2: `add x10,x1,x2`
  - 3: `sub x10,x1,x2`
  - 4: `and x10,x1,x2`
  - 5: `or x10,x1,x2`
  - 6: `xor x10,x1,x2`
  - 7: `slt x10,x2,x1`
  - 8: `sw x1,0(x0)`
  - 9: `lw x10,0(x0)`
  - 10: `addi x3,x0,4`
  - 11: `addi x10,x10,100`
  - 12: `addi x3,x3,-1`
  - 13: `bne x3,x0,-8`
  - 14: `jal x0,0`, the halt self-loop.
- Arithmetic: 32-bit two's complement, wrap on overflow. `out` truncates x10 to bits [9:0].

## Timing
- Reset: any rising edge with `reset`=1 sets:
  - PC=0;
  - all registers, including x10, to 0, so `out`=0;
  - all data RAM words to 0.
- Reset takes priority over every instruction effect at that edge.
- Before the first reset edge, state and `out` are undefined.
- Latency: the k-th rising edge after reset deasserts executes ROM word k-1 (no branches). Its register write is visible on `out` immediately after that edge.
- LW is combinational-read within the same cycle; the loaded value lands in rd at that instruction's edge. SW writes RAM at its edge.
- Branch/jump target takes effect at the next edge; there are no delay slots and no stalls.
- Reset mid-program: the program restarts from word 0 and the previous RAM/register contents are lost.
- Expected `out` after edge n (edge 1 = first edge with reset low):
  - n=1,2: 0
  - n=3: 8
  - n=4: 2
  - n=5: 1
  - n=6: 7
  - n=7: 6
  - n=8: 1
  - n=9: 1
  - n=10: 5
  - n=11: 5
  - n=12: 105
  - n=15: 205
  - n=18: 305
  - n=21: 405
  - n≥21: 405, held forever; PC stays 0x38 from edge 24 on.

## Test plan
- Hold reset high for 10 cycles, then release -> `out`=0 during reset and through edge 2; `out`=8 after edge 3.
- ALU sweep -> after edges 4..8, `out` = 2, 1, 7, 6, 1 (SUB, AND, OR, XOR, SLT).
- Memory -> edge 9 stores 5 at RAM[0]; after edge 10, `out`=5 and RAM[0]=5.
- Branch loop -> `out` steps 105 (edge 12), 205 (15), 305 (18), 405 (21); x3 reaches 0 at edge 22; the BNE at edge 23 falls through.
- Halt -> from edge 24 through 100+ cycles, PC=0x38, `out`=405 constant, x1=5, x2=3, x0=0.
- Mid-run reset at edge 16 for 3 cycles -> `out`=0 and RAM[0]=0 immediately; after release the sequence 8, 2, 1, 7, 6, 1, ... repeats from the same edge offsets.
